// File: rtl/data_memory_pipe.sv
// MIPS MEM-stage data memory: byte/half/word loads and stores with range, alignment and size checks.
// One-cycle registered response; a held response (resp_valid & ~resp_ready) blocks new requests.
module data_memory_pipe #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          INIT_ONE  = 1,
    parameter int          ERR_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          accept;
    logic          bad_size;
    logic          bad_range;
    logic          bad_align;
    logic          err;
    logic [31:0]   init_word;
    logic [31:0]   cur_word;
    logic [31:0]   lane_mask;
    logic [31:0]   lane_data;
    logic [31:0]   store_word;
    logic [31:0]   load_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    assign req_ready = reset & (~resp_valid | resp_ready);
    assign accept    = req_valid & req_ready;

    // BASE_ADDR is word-aligned, so the offset's low bits are the byte lane.
    assign off  = req_addr - BASE_ADDR;
    assign idx  = off[AW+1:2];
    assign lane = off[1:0];

    assign bad_size  = (req_size == SZ_RSVD);
    assign bad_range = |off[31:AW+2];
    assign bad_align = ((req_size == SZ_HALF) & lane[0]) |
                       ((req_size == SZ_WORD) & (|lane));
    assign err       = bad_size | bad_range | bad_align;

    // The array holds data XOR'd with the power-up image, so an all-zero array
    // reads back as the specified initial contents without any init sequence.
    assign init_word = ((INIT_ONE != 0) && (idx == AW'(1))) ? 32'h1 : 32'h0;
    assign cur_word  = mem[idx] ^ init_word;

    always_comb begin
        lane_mask = 32'hFFFF_FFFF;
        lane_data = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                lane_mask = 32'h0000_00FF << {lane, 3'b000};
                lane_data = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                lane_data = {2{req_wdata[15:0]}};
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                lane_data = req_wdata;
            end
        endcase
    end

    assign store_word = (cur_word & ~lane_mask) | (lane_data & lane_mask);

    always_comb begin
        ld_byte = cur_word[7:0];
        case (lane)
            2'd0:    ld_byte = cur_word[7:0];
            2'd1:    ld_byte = cur_word[15:8];
            2'd2:    ld_byte = cur_word[23:16];
            default: ld_byte = cur_word[31:24];
        endcase
    end

    assign ld_half = lane[1] ? cur_word[31:16] : cur_word[15:0];

    always_comb begin
        load_data = cur_word;
        case (req_size)
            SZ_BYTE: load_data = req_unsigned ? {24'h0, ld_byte}
                                              : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: load_data = req_unsigned ? {16'h0, ld_half}
                                              : {{16{ld_half[15]}}, ld_half};
            default: load_data = cur_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            mem[idx] <= store_word ^ init_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            err_count  <= '0;
        end else begin
            if (accept) begin
                resp_valid <= 1'b1;
                resp_err   <= err;
                resp_rdata <= (err || req_we) ? 32'h0 : load_data;
                if (err && (err_count != {ERR_W{1'b1}})) begin
                    err_count <= err_count + 1'b1;
                end
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench for data_memory_pipe: vector table plus backpressure and reset-during-response sequences.
module tb_data_memory_pipe;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] err_count;

    int total_cnt = 0;
    int pass_cnt  = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    data_memory_pipe #(
        .DEPTH(1024), .BASE_ADDR(32'h0), .INIT_ONE(1), .ERR_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.uns = uns;
        v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
    endtask

    // Issue one request, wait (bounded) for acceptance, then check the registered response.
    task automatic issue(input vec_t v);
        int n;
        drive(v);
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            check({v.name, "_accept_timeout"}, 32'(req_ready), 32'h1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            check({v.name, "_valid"}, 32'(resp_valid), 32'h1);
            check({v.name, "_rdata"}, resp_rdata, v.exp_rdata);
            check({v.name, "_err"}, 32'(resp_err), 32'(v.exp_err));
        end
    endtask

    initial begin
        int   exp_errs;
        vec_t a;
        vec_t b;

        tbl.push_back(mk("lw_4_init",      1'b0, 2'b10, 1'b0, 32'h4,    32'h0,        32'h0000_0001, 1'b0));
        tbl.push_back(mk("sw_8",           1'b1, 2'b10, 1'b0, 32'h8,    32'hAABB_CCDD, 32'h0,         1'b0));
        tbl.push_back(mk("sb_9",           1'b1, 2'b00, 1'b0, 32'h9,    32'h0000_0011, 32'h0,         1'b0));
        tbl.push_back(mk("lbu_9",          1'b0, 2'b00, 1'b1, 32'h9,    32'h0,        32'h0000_0011, 1'b0));
        tbl.push_back(mk("lb_b",           1'b0, 2'b00, 1'b0, 32'hB,    32'h0,        32'hFFFF_FFAA, 1'b0));
        tbl.push_back(mk("lhu_a",          1'b0, 2'b01, 1'b1, 32'hA,    32'h0,        32'h0000_AABB, 1'b0));
        tbl.push_back(mk("lw_8",           1'b0, 2'b10, 1'b0, 32'h8,    32'h0,        32'hAABB_11DD, 1'b0));
        tbl.push_back(mk("lh_a_signed",    1'b0, 2'b01, 1'b0, 32'hA,    32'h0,        32'hFFFF_AABB, 1'b0));
        tbl.push_back(mk("lh_8",           1'b0, 2'b01, 1'b0, 32'h8,    32'h0,        32'h0000_11DD, 1'b0));
        tbl.push_back(mk("lb_8",           1'b0, 2'b00, 1'b0, 32'h8,    32'h0,        32'hFFFF_FFDD, 1'b0));
        tbl.push_back(mk("lw_8_uns",       1'b0, 2'b10, 1'b1, 32'h8,    32'h0,        32'hAABB_11DD, 1'b0));
        tbl.push_back(mk("lh_3_misalign",  1'b0, 2'b01, 1'b0, 32'h3,    32'h0,        32'h0,         1'b1));
        tbl.push_back(mk("lw_6_misalign",  1'b0, 2'b10, 1'b0, 32'h6,    32'h0,        32'h0,         1'b1));
        tbl.push_back(mk("sz11_store_8",   1'b1, 2'b11, 1'b0, 32'h8,    32'h1234_5678, 32'h0,         1'b1));
        tbl.push_back(mk("lw_8_after_rsv", 1'b0, 2'b10, 1'b0, 32'h8,    32'h0,        32'hAABB_11DD, 1'b0));
        tbl.push_back(mk("lw_oor",         1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,        32'h0,         1'b1));
        tbl.push_back(mk("sw_oor",         1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEAD_BEEF, 32'h0,         1'b1));
        tbl.push_back(mk("lw_0_no_alias",  1'b0, 2'b10, 1'b0, 32'h0,    32'h0,        32'h0,         1'b0));
        tbl.push_back(mk("sh_e",           1'b1, 2'b01, 1'b0, 32'hE,    32'hFFFF_1234, 32'h0,         1'b0));
        tbl.push_back(mk("sb_c",           1'b1, 2'b00, 1'b0, 32'hC,    32'h0000_0080, 32'h0,         1'b0));
        tbl.push_back(mk("lb_c",           1'b0, 2'b00, 1'b0, 32'hC,    32'h0,        32'hFFFF_FF80, 1'b0));
        tbl.push_back(mk("lw_c",           1'b0, 2'b10, 1'b0, 32'hC,    32'h0,        32'h1234_0080, 1'b0));

        reset        = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h4;
        req_wdata    = 32'h0;
        resp_ready   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",  32'(req_ready),  32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata,      32'h0);
        check("rst_resp_err",   32'(resp_err),   32'h0);
        check("rst_err_count",  32'(err_count),  32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        exp_errs = 0;
        foreach (tbl[i]) begin
            issue(tbl[i]);
            if (tbl[i].exp_err) exp_errs++;
        end
        @(posedge clk); #1;
        check("err_count_table", 32'(err_count), 32'(exp_errs));
        check("drained_valid",   32'(resp_valid), 32'h0);

        // Backpressure: response A held for 3 cycles while B waits.
        a = mk("bp_a", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hAABB_11DD, 1'b0);
        b = mk("bp_b", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0000_0001, 1'b0);
        resp_ready = 1'b0;
        drive(a);
        @(posedge clk); #1;
        drive(b);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_req_ready_low", 32'(req_ready),  32'h0);
            check("bp_hold_valid",    32'(resp_valid), 32'h1);
            check("bp_hold_rdata",    resp_rdata,      32'hAABB_11DD);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_b_valid", 32'(resp_valid), 32'h1);
        check("bp_b_rdata", resp_rdata,      32'h0000_0001);
        check("bp_b_err",   32'(resp_err),   32'h0);
        @(posedge clk); #1;
        check("bp_drained", 32'(resp_valid), 32'h0);

        // Reset while a response is pending.
        resp_ready = 1'b0;
        drive(b);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst2_pending", 32'(resp_valid), 32'h1);
        reset = 1'b0;
        #1;
        check("rst2_valid_drop", 32'(resp_valid), 32'h0);
        check("rst2_req_ready",  32'(req_ready),  32'h0);
        check("rst2_err_count",  32'(err_count),  32'h0);
        @(negedge clk);
        reset      = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        issue(mk("rst2_lw_8", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hAABB_11DD, 1'b0));
        issue(mk("rst2_lw_4", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0000_0001, 1'b0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
